// File: rtl/cpu_pkg.sv
// Shared encodings for the simple CPU: sequencer states, opcodes, branch
// selects and fault codes.
package cpu_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_ALU_1 = 8'h01;
    localparam logic [7:0] OP_ALU_2 = 8'h02;
    localparam logic [7:0] OP_ALU_3 = 8'h03;
    localparam logic [7:0] OP_ALU_4 = 8'h04;
    localparam logic [7:0] OP_ALU_5 = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;

    localparam logic [1:0] BSEL_SEQ  = 2'b00;
    localparam logic [1:0] BSEL_JUMP = 2'b01;
    localparam logic [1:0] BSEL_BEQ  = 2'b10;
    localparam logic [1:0] BSEL_BNE  = 2'b11;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    function automatic logic opcode_legal(input logic [7:0] opcode);
        return (opcode <= OP_BNE);
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, jump, beq and bne targets.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [7:0]      offset_i,
    input  logic [1:0]      bsel_i,
    input  logic            zero_i,
    output logic [PC_W-1:0] next_pc_o
);

    logic [PC_W-1:0] seq_s;
    logic [PC_W-1:0] tgt_s;

    // Word offset is sign-extended and scaled to bytes; wrap is intentional.
    always_comb begin
        seq_s = pc_i + PC_W'(32'd4);
        tgt_s = seq_s + {{(PC_W-10){offset_i[7]}}, offset_i, 2'b00};
        case (bsel_i)
            BSEL_SEQ:  next_pc_o = seq_s;
            BSEL_JUMP: next_pc_o = tgt_s;
            BSEL_BEQ:  next_pc_o = zero_i ? tgt_s : seq_s;
            BSEL_BNE:  next_pc_o = zero_i ? seq_s : tgt_s;
            default:   next_pc_o = seq_s;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: fetch handshake, instruction register,
// write-back strobe timing, program counter and fault halting.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W          = 32,
    parameter logic [PC_W-1:0] RESET_PC      = '0,
    parameter int              FETCH_TIMEOUT = 16
) (
    input  logic            CLK,
    input  logic            RESET_N,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     instr_out,
    input  logic            writeable_in,
    input  logic [1:0]      bselect_in,
    input  logic            zero_in,
    output logic            reg_write_en,
    output logic [PC_W-1:0] pc_out,
    output logic            halted,
    output logic [1:0]      fault_code
);

    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);

    logic [2:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [31:0]      ir_q,     ir_d;
    logic [PC_W-1:0]  pc_q,     pc_d;
    logic [1:0]       fault_q,  fault_d;
    logic             req_q,    req_d;
    logic             we_q,     we_d;
    logic             halted_q, halted_d;
    logic [PC_W-1:0]  next_pc_s;

    pc_next_calc #(
        .PC_W (PC_W)
    ) u_pc_next_calc (
        .pc_i      (pc_q),
        .offset_i  (ir_q[23:16]),
        .bsel_i    (bselect_in),
        .zero_i    (zero_in),
        .next_pc_o (next_pc_s)
    );

    // Next-state, IR, PC and fault logic for the sequencer FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                cnt_d   = '0;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(FETCH_TIMEOUT - 1)) begin
                    state_d = ST_HALT;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (opcode_legal(ir_q[31:24])) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_HALT;
                    fault_d = FAULT_ILLEGAL;
                end
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                pc_d    = next_pc_s;
                state_d = ST_FETCH;
                cnt_d   = '0;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the state being entered, so each is valid
    // for exactly the cycles spent in that state.
    always_comb begin
        req_d    = (state_d == ST_FETCH);
        we_d     = (state_d == ST_WB) && writeable_in;
        halted_d = (state_d == ST_HALT);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ir_q     <= 32'h0000_0000;
            pc_q     <= RESET_PC;
            fault_q  <= FAULT_NONE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            fault_q  <= fault_d;
            req_q    <= req_d;
            we_q     <= we_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign instr_out    = ir_q;
    assign reg_write_en = we_q;
    assign pc_out       = pc_q;
    assign halted       = halted_q;
    assign fault_code   = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr_out;
    logic        writeable_in;
    logic [1:0]  bselect_in;
    logic        zero_in;
    logic        reg_write_en;
    logic [31:0] pc_out;
    logic        halted;
    logic [1:0]  fault_code;

    typedef struct packed {
        logic        wen;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_pc;

    pc_sequencer #(
        .PC_W          (32),
        .RESET_PC      (32'h0000_0000),
        .FETCH_TIMEOUT (16)
    ) dut (
        .CLK          (clk),
        .RESET_N      (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .instr_out    (instr_out),
        .writeable_in (writeable_in),
        .bselect_in   (bselect_in),
        .zero_in      (zero_in),
        .reg_write_en (reg_write_en),
        .pc_out       (pc_out),
        .halted       (halted),
        .fault_code   (fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [7:0] off,
                                               input logic [1:0] bsel, input logic zero);
        int          soff;
        logic [31:0] seq;
        logic [31:0] tgt;
        soff = int'($signed(off));
        seq  = pc + 32'd4;
        tgt  = seq + 32'(soff * 4);
        case (bsel)
            2'b00:   return seq;
            2'b01:   return tgt;
            2'b10:   return zero ? tgt : seq;
            default: return zero ? seq : tgt;
        endcase
    endfunction

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", 64'(imem_req), 64'd1);
    endtask

    // One full instruction: fetch with optional wait cycles, then DECODE, EXEC, WB.
    task automatic do_instr(input logic [31:0] word, input int waits, input logic wen,
                            input logic [1:0] bsel, input logic zero, input logic keep_ready);
        exp_t e;
        imem_ready = 1'b0;
        wait_req();
        check("fetch_addr", 64'(imem_addr), 64'(exp_pc));
        writeable_in = wen;
        bselect_in   = bsel;
        zero_in      = zero;
        sb_q.push_back('{wen: wen, pc: model_next(exp_pc, word[23:16], bsel, zero)});
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("wait_req_held", 64'(imem_req), 64'd1);
            check("wait_addr_stable", 64'(imem_addr), 64'(exp_pc));
        end
        imem_rdata = word;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_rdata = 32'h09FF_FFFF;
        imem_ready = keep_ready;
        check("ir_latched", 64'(instr_out), 64'(word));
        check("decode_req_low", 64'(imem_req), 64'd0);
        check("decode_we_low", 64'(reg_write_en), 64'd0);
        @(negedge clk);
        check("exec_we_low", 64'(reg_write_en), 64'd0);
        @(negedge clk);
        e = sb_q.pop_front();
        check("wb_we", 64'(reg_write_en), 64'(e.wen));
        check("wb_pc_unchanged", 64'(pc_out), 64'(exp_pc));
        @(negedge clk);
        imem_ready = 1'b0;
        check("next_pc", 64'(pc_out), 64'(e.pc));
        check("refetch_req", 64'(imem_req), 64'd1);
        check("post_wb_we_low", 64'(reg_write_en), 64'd0);
        exp_pc = e.pc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_we", 64'(reg_write_en), 64'd0);
        check("rst_pc", 64'(pc_out), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_fault", 64'(fault_code), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 32'h0000_0000;
        sb_q.delete();
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_rdata   = 32'h0000_0000;
        imem_ready   = 1'b0;
        writeable_in = 1'b0;
        bselect_in   = 2'b00;
        zero_in      = 1'b0;
        exp_pc       = 32'h0000_0000;
        #1;
        check("reset_pc", 64'(pc_out), 64'd0);
        check("reset_ir", 64'(instr_out), 64'd0);
        check("reset_req", 64'(imem_req), 64'd0);
        check("reset_we", 64'(reg_write_en), 64'd0);
        check("reset_halted", 64'(halted), 64'd0);
        check("reset_fault", 64'(fault_code), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("idle_req_low", 64'(imem_req), 64'd0);

        // Sequential loadi stream, ready held high outside FETCH.
        do_instr(32'h0001_0203, 0, 1'b1, 2'b00, 1'b0, 1'b1);
        do_instr(32'h0002_0304, 0, 1'b1, 2'b00, 1'b0, 1'b1);
        do_instr(32'h0003_0405, 0, 1'b1, 2'b00, 1'b0, 1'b1);
        do_instr(32'h0004_0506, 0, 1'b1, 2'b00, 1'b0, 1'b0);
        // Branches around pc=0x10.
        do_instr(32'h0703_0000, 0, 1'b0, 2'b10, 1'b1, 1'b0);
        do_instr(32'h06FB_0000, 0, 1'b0, 2'b01, 1'b0, 1'b0);
        do_instr(32'h0703_0000, 0, 1'b0, 2'b10, 1'b0, 1'b0);
        do_instr(32'h06FE_0000, 0, 1'b0, 2'b01, 1'b0, 1'b0);
        do_instr(32'h08FE_0000, 0, 1'b0, 2'b11, 1'b0, 1'b0);
        do_instr(32'h0005_0607, 3, 1'b1, 2'b00, 1'b0, 1'b0);
        do_instr(32'h06FE_0000, 0, 1'b0, 2'b01, 1'b0, 1'b1);
        // Most negative offset wraps below zero, then climb to the top and wrap.
        do_instr(32'h0680_0000, 0, 1'b0, 2'b01, 1'b0, 1'b0);
        do_instr(32'h067A_0000, 0, 1'b0, 2'b01, 1'b1, 1'b0);
        do_instr(32'h0006_0708, 0, 1'b1, 2'b00, 1'b0, 1'b0);
        do_instr(32'h08FE_0000, 0, 1'b0, 2'b11, 1'b1, 1'b0);

        // Fetch timeout.
        imem_ready = 1'b0;
        wait_req();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("to_not_yet", 64'(halted), 64'd0);
        end
        check("to_req_still", 64'(imem_req), 64'd1);
        @(negedge clk);
        check("to_halted", 64'(halted), 64'd1);
        check("to_fault", 64'(fault_code), 64'd2);
        check("to_req_low", 64'(imem_req), 64'd0);

        // Illegal opcode.
        do_reset();
        wait_req();
        imem_rdata = 32'h0900_0000;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_rdata = 32'h0000_0000;
        check("ill_decode_not_halted", 64'(halted), 64'd0);
        @(negedge clk);
        check("ill_halted", 64'(halted), 64'd1);
        check("ill_fault", 64'(fault_code), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ill_req_low", 64'(imem_req), 64'd0);
            check("ill_we_low", 64'(reg_write_en), 64'd0);
            check("ill_ir_held", 64'(instr_out), 64'h0900_0000);
            check("ill_pc_held", 64'(pc_out), 64'd0);
        end
        imem_ready = 1'b0;

        // Reset during WB with a pending write.
        do_reset();
        do_instr(32'h0007_0809, 0, 1'b1, 2'b00, 1'b0, 1'b0);
        wait_req();
        writeable_in = 1'b1;
        bselect_in   = 2'b00;
        imem_rdata   = 32'h0008_090A;
        imem_ready   = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wb_pre_reset_we", 64'(reg_write_en), 64'd1);
        check("wb_pre_reset_pc", 64'(pc_out), 64'd4);
        rst_n = 1'b0;
        #1;
        check("wb_rst_we", 64'(reg_write_en), 64'd0);
        check("wb_rst_pc", 64'(pc_out), 64'd0);
        check("wb_rst_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 32'h0000_0000;
        do_instr(32'h0009_0A0B, 0, 1'b1, 2'b00, 1'b0, 1'b0);

        // Reset during FETCH.
        imem_ready = 1'b0;
        wait_req();
        check("fetch_pre_reset_pc", 64'(pc_out), 64'd4);
        rst_n = 1'b0;
        #1;
        check("fetch_rst_req", 64'(imem_req), 64'd0);
        check("fetch_rst_pc", 64'(pc_out), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 32'h0000_0000;
        do_instr(32'h000A_0B0C, 0, 1'b1, 2'b00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
